// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: clock-enable pixel divider, VGA timing counters, incremental
// replicated read addressing, writable RGB444 palette and a 2-tick aligned output stage.
module vga_fb_scanout #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 1,
  parameter int PIX_BITS    = 1,
  parameter int SYNC_POL    = 0,
  parameter int FB_ADDRW    = $clog2((H_ACTIVE >> SCALE_SHIFT) * (V_ACTIVE >> SCALE_SHIFT))
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [FB_ADDRW-1:0] fb_addr,
  input  logic [PIX_BITS-1:0] fb_data,
  input  logic                pal_we,
  input  logic [PIX_BITS-1:0] pal_addr,
  input  logic [11:0]         pal_data,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam int RBW     = FB_ADDRW + 1;
  localparam int PAL_N   = 1 << PIX_BITS;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0]  SUB_LAST = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [RBW-1:0] FB_W_R   = RBW'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic           SYNC_ON  = 1'(SYNC_POL);

  logic [DW-1:0]  div_r;
  logic           pix_ce_s;
  logic [HW-1:0]  h_r;
  logic [VW-1:0]  v_r;
  logic [SW-1:0]  hsub_r, vsub_r;
  logic [RBW-1:0] col_r, row_r;
  logic           act_s;
  logic           act1_r, hs1_r, vs1_r, first1_r;
  logic [11:0]    pal_r [PAL_N];
  logic [11:0]    rgb_s;

  // Pixel tick generation and visible-region decode
  always_comb begin
    pix_ce_s = 1'b0;
    if (enable) begin
      pix_ce_s = (div_r == DIV_LAST);
    end else begin
      pix_ce_s = 1'b0;
    end
    act_s = (h_r < H_ACT) && (v_r < V_ACT);
  end

  // Clock-enable divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      div_r <= '0;
    else if (!enable)  div_r <= '0;
    else if (pix_ce_s) div_r <= '0;
    else               div_r <= div_r + DW'(1);
  end

  // Raster counters plus replicated column offset / row base (no multiply)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !enable) begin
      h_r <= '0; v_r <= '0; hsub_r <= '0; vsub_r <= '0; col_r <= '0; row_r <= '0;
    end else if (pix_ce_s) begin
      if (h_r == H_LAST) begin
        h_r <= '0; hsub_r <= '0; col_r <= '0;
        if (v_r == V_LAST) begin
          v_r <= '0; vsub_r <= '0; row_r <= '0;
        end else begin
          v_r <= v_r + VW'(1);
          if (v_r < V_ACT) begin
            if (vsub_r == SUB_LAST) begin
              vsub_r <= '0;
              row_r  <= row_r + FB_W_R;
            end else begin
              vsub_r <= vsub_r + SW'(1);
            end
          end
        end
      end else begin
        h_r <= h_r + HW'(1);
        if (h_r < H_ACT) begin
          if (hsub_r == SUB_LAST) begin
            hsub_r <= '0;
            col_r  <= col_r + RBW'(1);
          end else begin
            hsub_r <= hsub_r + SW'(1);
          end
        end
      end
    end
  end

  // Stage 1: address register and timing flags for the pixel being fetched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !enable) begin
      fb_addr <= '0; act1_r <= 1'b0; hs1_r <= 1'b0; vs1_r <= 1'b0; first1_r <= 1'b0;
    end else if (pix_ce_s) begin
      if (act_s) fb_addr <= FB_ADDRW'(row_r + col_r);
      act1_r   <= act_s;
      hs1_r    <= (h_r >= HS_BEG) && (h_r <= HS_LAST);
      vs1_r    <= (v_r >= VS_BEG) && (v_r <= VS_LAST);
      first1_r <= (h_r == '0) && (v_r == '0);
    end
  end

  // Palette storage; lookups this cycle see the value before a same-cycle write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_N; i++) pal_r[i] <= (i == 0) ? 12'h000 : 12'hFFF;
    end else if (pal_we) begin
      pal_r[pal_addr] <= pal_data;
    end
  end

  // Palette lookup with blanking
  always_comb begin
    rgb_s = 12'h000;
    if (act1_r) begin
      rgb_s = pal_r[fb_data];
    end else begin
      rgb_s = 12'h000;
    end
  end

  // Stage 2: registered pins, syncs and frame marker aligned with RGB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || !enable) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs      <= ~SYNC_ON;
      vga_vs      <= ~SYNC_ON;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce_s && first1_r;
      if (pix_ce_s) begin
        {vga_r, vga_g, vga_b} <= rgb_s;
        vga_hs <= hs1_r ? SYNC_ON : ~SYNC_ON;
        vga_vs <= vs1_r ? SYNC_ON : ~SYNC_ON;
      end
    end
  end
endmodule
